// File: rtl/sc_reg_counter_pkg.sv
// Shared definitions for the multi-mode counter register.
// Holds the mode encodings and a constant clog2 helper.
package sc_reg_counter_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_UP   = 3'b001;
    localparam logic [2:0] MODE_DOWN = 3'b010;
    localparam logic [2:0] MODE_SHL  = 3'b011;
    localparam logic [2:0] MODE_SHR  = 3'b100;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest = rest >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sc_reg_counter_multi_prescaler.sv
// Enable prescaler: emits a tick on every PRESCALE-th enabled cycle.
// Clear and reset both return the phase to zero.
module sc_prescaler_tick
    import sc_reg_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sc_reg_counter_multi.sv
// Bounded up/down counter with load, clear, serial shift and prescaled
// stepping; used as score/position/timer register in game datapaths.
module sc_reg_counter_multi
    import sc_reg_counter_pkg::*;
#(
    parameter int RegCOUNTER_DATAWIDTH   = 8,
    parameter int RegCOUNTER_MAX_VALUE   = (2 ** RegCOUNTER_DATAWIDTH) - 1,
    parameter int RegCOUNTER_MIN_VALUE   = 0,
    parameter int RegCOUNTER_RESET_VALUE = 0,
    parameter int RegCOUNTER_SATURATE    = 0,
    parameter int RegCOUNTER_PRESCALE    = 1
) (
    input  logic                            SC_RegCOUNTER_CLOCK_50,
    input  logic                            SC_RegCOUNTER_RESET_InHigh,
    input  logic                            SC_RegCOUNTER_clear_InLow,
    input  logic                            SC_RegCOUNTER_load_InLow,
    input  logic                            SC_RegCOUNTER_enable_InHigh,
    input  logic [2:0]                      SC_RegCOUNTER_mode_InBUS,
    input  logic                            SC_RegCOUNTER_serial_InHigh,
    input  logic [RegCOUNTER_DATAWIDTH-1:0] SC_RegCOUNTER_data_InBUS,
    output logic [RegCOUNTER_DATAWIDTH-1:0] SC_RegCOUNTER_data_OutBUS,
    output logic                            SC_RegCOUNTER_terminal_OutHigh,
    output logic                            SC_RegCOUNTER_wrap_OutHigh
);

    localparam int W = RegCOUNTER_DATAWIDTH;
    localparam logic [W-1:0] MAXV = W'(RegCOUNTER_MAX_VALUE);
    localparam logic [W-1:0] MINV = W'(RegCOUNTER_MIN_VALUE);
    localparam logic [W-1:0] RSTV = W'(RegCOUNTER_RESET_VALUE);
    localparam bit SAT = (RegCOUNTER_SATURATE != 0);

    logic [W-1:0] regQ;
    logic [W-1:0] regNext;
    logic         wrapQ;
    logic         wrapNext;
    logic         stepMode;
    logic         preClear;
    logic         tick;

    assign stepMode = (SC_RegCOUNTER_mode_InBUS >= MODE_UP) &&
                      (SC_RegCOUNTER_mode_InBUS <= MODE_SHR);
    assign preClear = !SC_RegCOUNTER_clear_InLow ||
                      !SC_RegCOUNTER_load_InLow;

    sc_prescaler_tick #(
        .PRESCALE(RegCOUNTER_PRESCALE)
    ) prescaler (
        .clock (SC_RegCOUNTER_CLOCK_50),
        .reset (SC_RegCOUNTER_RESET_InHigh),
        .clear (preClear),
        .enable(SC_RegCOUNTER_enable_InHigh && stepMode),
        .tick  (tick)
    );

    always_comb begin
        regNext  = regQ;
        wrapNext = 1'b0;
        if (tick) begin
            case (SC_RegCOUNTER_mode_InBUS)
                MODE_UP: begin
                    if (regQ >= MAXV) begin
                        regNext  = SAT ? MAXV : MINV;
                        wrapNext = !SAT;
                    end else begin
                        regNext = regQ + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (regQ <= MINV) begin
                        regNext  = SAT ? MINV : MAXV;
                        wrapNext = !SAT;
                    end else begin
                        regNext = regQ - 1'b1;
                    end
                end
                MODE_SHL: regNext = {regQ[W-2:0], SC_RegCOUNTER_serial_InHigh};
                MODE_SHR: regNext = {SC_RegCOUNTER_serial_InHigh, regQ[W-1:1]};
                default:  regNext = regQ;
            endcase
        end
    end

    always_ff @(posedge SC_RegCOUNTER_CLOCK_50) begin
        if (SC_RegCOUNTER_RESET_InHigh) begin
            regQ  <= RSTV;
            wrapQ <= 1'b0;
        end else if (!SC_RegCOUNTER_clear_InLow) begin
            regQ  <= RSTV;
            wrapQ <= 1'b0;
        end else if (!SC_RegCOUNTER_load_InLow) begin
            regQ  <= SC_RegCOUNTER_data_InBUS;
            wrapQ <= 1'b0;
        end else begin
            regQ  <= regNext;
            wrapQ <= wrapNext;
        end
    end

    assign SC_RegCOUNTER_data_OutBUS = regQ;
    assign SC_RegCOUNTER_wrap_OutHigh = wrapQ;
    assign SC_RegCOUNTER_terminal_OutHigh =
        ((SC_RegCOUNTER_mode_InBUS == MODE_UP) && (regQ >= MAXV)) ||
        ((SC_RegCOUNTER_mode_InBUS == MODE_DOWN) && (regQ <= MINV));

endmodule

// File: tb/tb_sc_reg_counter_multi.sv
// Scoreboard bench: three counters (wrap, saturate, prescale-3)
// share stimulus; each scenario queues expectations and checks them.
module tb_sc_reg_counter_multi;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] UP   = 3'b001;
    localparam logic [2:0] DOWN = 3'b010;
    localparam logic [2:0] SHL  = 3'b011;
    localparam logic [2:0] SHR  = 3'b100;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] data;
        logic       wrap;
        logic       ct;
        logic       term;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clrN;
    logic       ldN;
    logic       en;
    logic [2:0] mode;
    logic       ser;
    logic [3:0] din;
    logic [3:0] dout [3];
    logic       wout [3];
    logic       tout [3];

    exp_t  sb[$];
    int    checks = 0;
    int    failures = 0;
    string tname;

    always #5 clk = ~clk;

    sc_reg_counter_multi #(
        .RegCOUNTER_DATAWIDTH(4), .RegCOUNTER_MAX_VALUE(9),
        .RegCOUNTER_MIN_VALUE(0), .RegCOUNTER_RESET_VALUE(0),
        .RegCOUNTER_SATURATE(0), .RegCOUNTER_PRESCALE(1)
    ) dutWrap (
        .SC_RegCOUNTER_CLOCK_50(clk), .SC_RegCOUNTER_RESET_InHigh(rst),
        .SC_RegCOUNTER_clear_InLow(clrN), .SC_RegCOUNTER_load_InLow(ldN),
        .SC_RegCOUNTER_enable_InHigh(en), .SC_RegCOUNTER_mode_InBUS(mode),
        .SC_RegCOUNTER_serial_InHigh(ser), .SC_RegCOUNTER_data_InBUS(din),
        .SC_RegCOUNTER_data_OutBUS(dout[0]),
        .SC_RegCOUNTER_terminal_OutHigh(tout[0]),
        .SC_RegCOUNTER_wrap_OutHigh(wout[0])
    );

    sc_reg_counter_multi #(
        .RegCOUNTER_DATAWIDTH(4), .RegCOUNTER_MAX_VALUE(9),
        .RegCOUNTER_MIN_VALUE(0), .RegCOUNTER_RESET_VALUE(0),
        .RegCOUNTER_SATURATE(1), .RegCOUNTER_PRESCALE(1)
    ) dutSat (
        .SC_RegCOUNTER_CLOCK_50(clk), .SC_RegCOUNTER_RESET_InHigh(rst),
        .SC_RegCOUNTER_clear_InLow(clrN), .SC_RegCOUNTER_load_InLow(ldN),
        .SC_RegCOUNTER_enable_InHigh(en), .SC_RegCOUNTER_mode_InBUS(mode),
        .SC_RegCOUNTER_serial_InHigh(ser), .SC_RegCOUNTER_data_InBUS(din),
        .SC_RegCOUNTER_data_OutBUS(dout[1]),
        .SC_RegCOUNTER_terminal_OutHigh(tout[1]),
        .SC_RegCOUNTER_wrap_OutHigh(wout[1])
    );

    sc_reg_counter_multi #(
        .RegCOUNTER_DATAWIDTH(4), .RegCOUNTER_MAX_VALUE(9),
        .RegCOUNTER_MIN_VALUE(0), .RegCOUNTER_RESET_VALUE(0),
        .RegCOUNTER_SATURATE(0), .RegCOUNTER_PRESCALE(3)
    ) dutPre (
        .SC_RegCOUNTER_CLOCK_50(clk), .SC_RegCOUNTER_RESET_InHigh(rst),
        .SC_RegCOUNTER_clear_InLow(clrN), .SC_RegCOUNTER_load_InLow(ldN),
        .SC_RegCOUNTER_enable_InHigh(en), .SC_RegCOUNTER_mode_InBUS(mode),
        .SC_RegCOUNTER_serial_InHigh(ser), .SC_RegCOUNTER_data_InBUS(din),
        .SC_RegCOUNTER_data_OutBUS(dout[2]),
        .SC_RegCOUNTER_terminal_OutHigh(tout[2]),
        .SC_RegCOUNTER_wrap_OutHigh(wout[2])
    );

    task automatic drive(input logic r, input logic c, input logic l,
                         input logic e, input logic [2:0] m,
                         input logic s, input logic [3:0] d);
        rst = r; clrN = c; ldN = l; en = e; mode = m; ser = s; din = d;
    endtask

    task automatic push(input int sel, input int data, input bit wrap,
                        input bit ct, input bit term);
        exp_t x;
        x.sel = 2'(sel); x.data = 4'(data);
        x.wrap = wrap; x.ct = ct; x.term = term;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        exp_t e;
        tname = "reset";
        drive(1, 1, 1, 0, HOLD, 0, 4'd5);
        for (int s = 0; s < 3; s++) push(s, 0, 0, 1, 0);
        @(posedge clk); #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (dout[e.sel] !== e.data || wout[e.sel] !== e.wrap ||
                (e.ct && tout[e.sel] !== e.term)) begin
                failures++;
                $display("FAIL %s dut%0d data=%0d exp=%0d wrap=%b exp=%b term=%b exp=%b",
                         tname, e.sel, dout[e.sel], e.data, wout[e.sel], e.wrap,
                         tout[e.sel], e.term);
            end
        end
    endtask

    task automatic test_count_up();
        exp_t e;
        tname = "count_up";
        drive(0, 1, 1, 1, UP, 0, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            push(0, i % 10, i == 10, 1, (i % 10) == 9);
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (dout[e.sel] !== e.data || wout[e.sel] !== e.wrap ||
                    (e.ct && tout[e.sel] !== e.term)) begin
                    failures++;
                    $display("FAIL %s cyc%0d data=%0d exp=%0d wrap=%b exp=%b term=%b exp=%b",
                             tname, i, dout[e.sel], e.data, wout[e.sel], e.wrap,
                             tout[e.sel], e.term);
                end
            end
        end
    endtask

    task automatic test_count_down();
        exp_t e;
        int wv[5] = '{2, 1, 0, 9, 8};
        int sv[5] = '{2, 1, 0, 0, 0};
        tname = "count_down";
        for (int i = 0; i <= 5; i++) begin
            if (i == 0) begin
                drive(0, 1, 0, 0, HOLD, 0, 4'd3);
                for (int s = 0; s < 3; s++) push(s, 3, 0, 1, 0);
            end else begin
                drive(0, 1, 1, 1, DOWN, 0, 4'd0);
                push(0, wv[i-1], i == 4, 1, wv[i-1] == 0);
                push(1, sv[i-1], 0, 1, sv[i-1] == 0);
            end
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (dout[e.sel] !== e.data || wout[e.sel] !== e.wrap ||
                    (e.ct && tout[e.sel] !== e.term)) begin
                    failures++;
                    $display("FAIL %s cyc%0d dut%0d data=%0d exp=%0d wrap=%b exp=%b term=%b exp=%b",
                             tname, i, e.sel, dout[e.sel], e.data, wout[e.sel], e.wrap,
                             tout[e.sel], e.term);
                end
            end
        end
    endtask

    task automatic test_prescale();
        exp_t e;
        tname = "prescale";
        for (int i = 0; i <= 14; i++) begin
            if (i == 0) begin
                drive(0, 1, 0, 0, HOLD, 0, 4'd0);
                push(2, 0, 0, 1, 0);
            end else begin
                drive(0, 1, 1, !(i == 11 || i == 12), UP, 0, 4'd0);
                push(2, (i <= 9) ? i / 3 : ((i == 14) ? 4 : 3), 0, 1, 0);
            end
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (dout[e.sel] !== e.data || wout[e.sel] !== e.wrap ||
                    (e.ct && tout[e.sel] !== e.term)) begin
                    failures++;
                    $display("FAIL %s cyc%0d data=%0d exp=%0d wrap=%b exp=%b term=%b exp=%b",
                             tname, i, dout[e.sel], e.data, wout[e.sel], e.wrap,
                             tout[e.sel], e.term);
                end
            end
        end
    endtask

    task automatic test_shift();
        exp_t e;
        int v[5] = '{1, 3, 7, 15, 7};
        tname = "shift";
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(0, 1, 0, 0, HOLD, 0, 4'b0001);
            else if (i < 4) drive(0, 1, 1, 1, SHL, 1, 4'd0);
            else drive(0, 1, 1, 1, SHR, 0, 4'd0);
            push(0, v[i], 0, 1, 0);
            push(1, v[i], 0, 1, 0);
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (dout[e.sel] !== e.data || wout[e.sel] !== e.wrap ||
                    (e.ct && tout[e.sel] !== e.term)) begin
                    failures++;
                    $display("FAIL %s cyc%0d dut%0d data=%0d exp=%0d wrap=%b exp=%b term=%b exp=%b",
                             tname, i, e.sel, dout[e.sel], e.data, wout[e.sel], e.wrap,
                             tout[e.sel], e.term);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        tname = "out_of_range";
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                drive(0, 1, 0, 0, HOLD, 0, 4'd14);
                push(0, 14, 0, 1, 0); push(1, 14, 0, 1, 0);
            end else if (i == 1) begin
                drive(0, 1, 1, 1, UP, 0, 4'd0);
                push(0, 0, 1, 1, 0); push(1, 9, 0, 1, 1);
            end else begin
                drive(0, 1, 1, 0, HOLD, 0, 4'd0);
                push(0, 0, 0, 1, 0); push(1, 9, 0, 1, 0);
            end
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (dout[e.sel] !== e.data || wout[e.sel] !== e.wrap ||
                    (e.ct && tout[e.sel] !== e.term)) begin
                    failures++;
                    $display("FAIL %s cyc%0d dut%0d data=%0d exp=%0d wrap=%b exp=%b term=%b exp=%b",
                             tname, i, e.sel, dout[e.sel], e.data, wout[e.sel], e.wrap,
                             tout[e.sel], e.term);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        tname = "simultaneous";
        for (int i = 0; i < 7; i++) begin
            unique case (i)
                0: begin
                    drive(1, 0, 0, 1, UP, 0, 4'd5);
                    for (int s = 0; s < 3; s++) push(s, 0, 0, 0, 0);
                end
                1: begin
                    drive(0, 0, 0, 1, UP, 0, 4'd5);
                    for (int s = 0; s < 3; s++) push(s, 0, 0, 0, 0);
                end
                2: begin
                    drive(0, 1, 1, 1, UP, 0, 4'd0);
                    push(0, 1, 0, 0, 0); push(2, 0, 0, 0, 0);
                end
                3: begin
                    drive(0, 1, 0, 1, UP, 0, 4'd7);
                    for (int s = 0; s < 3; s++) push(s, 7, 0, 0, 0);
                end
                default: begin
                    drive(0, 1, 1, 1, UP, 0, 4'd0);
                    push(2, (i == 6) ? 8 : 7, 0, 0, 0);
                    push(0, (i == 6) ? 0 : i + 4, i == 6, 0, 0);
                end
            endcase
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (dout[e.sel] !== e.data || wout[e.sel] !== e.wrap ||
                    (e.ct && tout[e.sel] !== e.term)) begin
                    failures++;
                    $display("FAIL %s cyc%0d dut%0d data=%0d exp=%0d wrap=%b exp=%b",
                             tname, i, e.sel, dout[e.sel], e.data,
                             wout[e.sel], e.wrap);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_prescale();
        test_shift();
        test_out_of_range();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
